rom_load_sequencer: RTL and testbench

ROM_LOAD_SEQUENCER -- requirements
Module: rom_load_sequencer

---
 rtl/rom_load_pkg.sv | 26 ++
 rtl/rom_load_skid.sv | 41 ++++
 rtl/rom_load_sequencer.sv | 154 +++++++++++++++
 tb/tb_rom_load_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ROM download sequencer.
package rom_load_pkg;

  localparam int unsigned IO_ADDR_W = 25;
  localparam int unsigned DN_ADDR_W = 17;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CKSUM_W   = 16;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_DIP = 8'd254;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4
  } state_t;

  // One ROM byte on its way to the write port
  typedef struct packed {
    logic [DN_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]    data;
  } rom_beat_t;

endpackage

// File: rtl/rom_load_skid.sv
// One-entry buffer between the HPS download stream and the ROM write port;
// stalls the stream while a byte is held and the port is not ready.
module rom_load_skid
  import rom_load_pkg::*;
(
  input  logic      clk_sys,
  input  logic      reset_n,
  input  logic      capture,
  input  rom_beat_t beat_in,
  input  logic      dn_ready,
  output logic      dn_wr,
  output rom_beat_t beat_out,
  output logic      wait_c,
  output logic      xfer_c
);

  logic      valid_q;
  rom_beat_t beat_q;
  logic      accept_c;

  assign xfer_c   = valid_q && dn_ready;
  assign wait_c   = valid_q && !dn_ready;
  // A draining slot can be refilled in the same cycle, so only a stalled slot refuses
  assign accept_c = capture && !wait_c;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else if (accept_c) begin
      valid_q <= 1'b1;
      beat_q  <= beat_in;
    end else if (xfer_c) begin
      valid_q <= 1'b0;
    end
  end

  assign dn_wr    = valid_q;
  assign beat_out = beat_q;

endmodule

// File: rtl/rom_load_sequencer.sv
// ROM download sequencer: routes the HPS stream into the ROM write port and
// DIP registers, and holds the core in reset around downloads.
// Optional checksum of transferred bytes: define ROM_LOAD_CKSUM_EN.
module rom_load_sequencer
  import rom_load_pkg::*;
#(
  parameter int unsigned ROM_SIZE    = 32'h0001_0000,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 ioctl_download,
  input  logic                 ioctl_wr,
  input  logic [IO_ADDR_W-1:0] ioctl_addr,
  input  logic [DATA_W-1:0]    ioctl_dout,
  input  logic [7:0]           ioctl_index,
  output logic                 ioctl_wait,
  output logic [DN_ADDR_W-1:0] dn_addr,
  output logic [DATA_W-1:0]    dn_data,
  output logic                 dn_wr,
  input  logic                 dn_ready,
  input  logic                 reset_req,
  output logic                 core_reset,
  output logic [DATA_W-1:0]    dip_sw0,
  output logic [DATA_W-1:0]    dip_sw1,
  output logic                 load_done,
  output logic                 overflow,
  output logic [CKSUM_W-1:0]   cksum
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              load_entry_c, load_finish_c;
  logic              xfer_seen_q;

  logic      rom_wr_c, rom_in_range_c, capture_c, rom_ovf_c, dip_wr_c;
  logic      xfer_c, wait_c;
  rom_beat_t beat_in_c, beat_out;

  // Stream decode
  assign rom_wr_c       = ioctl_wr && (ioctl_index == IDX_ROM);
  assign rom_in_range_c = 32'(ioctl_addr) < ROM_SIZE;
  assign capture_c      = rom_wr_c && rom_in_range_c;
  assign rom_ovf_c      = rom_wr_c && !rom_in_range_c;
  assign dip_wr_c       = ioctl_wr && (ioctl_index == IDX_DIP)
                          && (ioctl_addr[IO_ADDR_W-1:1] == '0);

  assign beat_in_c.addr = ioctl_addr[DN_ADDR_W-1:0];
  assign beat_in_c.data = ioctl_dout;

  rom_load_skid u_skid (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .capture  (capture_c),
    .beat_in  (beat_in_c),
    .dn_ready (dn_ready),
    .dn_wr    (dn_wr),
    .beat_out (beat_out),
    .wait_c   (wait_c),
    .xfer_c   (xfer_c)
  );

  assign ioctl_wait = wait_c;
  assign dn_addr    = beat_out.addr;
  assign dn_data    = beat_out.data;

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Next state; the hold counter runs only while staying in HOLD
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = '0;
    load_finish_c = 1'b0;
    load_entry_c  = 1'b0;
    case (state_q)
      IDLE:  if (load_done) state_d = HOLD;
      LOAD:  if (!ioctl_download) state_d = DRAIN;
      DRAIN: begin
        if (!dn_wr) begin
          state_d       = HOLD;
          load_finish_c = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = RUN;
        else                         hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      RUN:     if (reset_req) state_d = HOLD;
      default: state_d = IDLE;
    endcase
    // A new download preempts everything, including a running hold
    if (ioctl_download) begin
      state_d       = LOAD;
      hold_cnt_d    = '0;
      load_finish_c = 1'b0;
      load_entry_c  = (state_q != LOAD);
    end
  end

  assign core_reset = (state_q != RUN) || reset_req;

  // Per-download status flags and DIP registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      xfer_seen_q <= 1'b0;
      load_done   <= 1'b0;
      overflow    <= 1'b0;
      dip_sw0     <= '0;
      dip_sw1     <= '0;
    end else begin
      if (load_entry_c)  xfer_seen_q <= 1'b0;
      else if (xfer_c)   xfer_seen_q <= 1'b1;

      if (load_entry_c)                      load_done <= 1'b0;
      else if (load_finish_c && xfer_seen_q) load_done <= 1'b1;

      if (rom_ovf_c)         overflow <= 1'b1;
      else if (load_entry_c) overflow <= 1'b0;

      if (dip_wr_c) begin
        if (ioctl_addr[0]) dip_sw1 <= ioctl_dout;
        else               dip_sw0 <= ioctl_dout;
      end
    end
  end

`ifdef ROM_LOAD_CKSUM_EN
  logic [CKSUM_W-1:0] cksum_q;

  // Wrap-around sum of bytes actually accepted by the ROM port
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)          cksum_q <= '0;
    else if (load_entry_c) cksum_q <= '0;
    else if (xfer_c)       cksum_q <= cksum_q + CKSUM_W'(beat_out.data);
  end

  assign cksum = cksum_q;
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Scoreboard bench for rom_load_sequencer: randomized downloads against a
// queue-based reference of the bytes the ROM port must see.
module tb_rom_load_sequencer;

  logic        clk_sys        = 1'b0;
  logic        reset_n        = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr       = 1'b0;
  logic [24:0] ioctl_addr     = '0;
  logic [7:0]  ioctl_dout     = '0;
  logic [7:0]  ioctl_index    = '0;
  logic        dn_ready       = 1'b1;
  logic        reset_req      = 1'b0;
  logic        ioctl_wait;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        core_reset;
  logic [7:0]  dip_sw0, dip_sw1;
  logic        load_done, overflow;
  logic [15:0] cksum;

  rom_load_sequencer dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_ready       (dn_ready),
    .reset_req      (reset_req),
    .core_reset     (core_reset),
    .dip_sw0        (dip_sw0),
    .dip_sw1        (dip_sw1),
    .load_done      (load_done),
    .overflow       (overflow),
    .cksum          (cksum)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // 0: always ready, 1: random, 2: stalled
  int ready_mode = 0;
  always @(posedge clk_sys) begin
    #1;
    case (ready_mode)
      0:       dn_ready = 1'b1;
      1:       dn_ready = 1'($urandom_range(0, 1));
      default: dn_ready = 1'b0;
    endcase
  end

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    int          exp_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t        sb[$];
  bit          chk_lat  = 1'b1;
  bit          loaded   = 1'b0;
  bit          exp_ovf  = 1'b0;
  logic [15:0] exp_sum  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every ROM port transfer must match the oldest expected byte
  always @(negedge clk_sys) begin
    exp_t e;
    if (reset_n && dn_wr && dn_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dn_wr: addr 0x%0h data 0x%0h with nothing expected", dn_addr, dn_data);
      end else begin
        e = sb.pop_front();
        check("dn_addr", 32'(dn_addr), 32'(e.addr));
        check("dn_data", 32'(dn_data), 32'(e.data));
        if (e.chk_lat) check("dn_latency", 32'(cyc), 32'(e.exp_cyc));
      end
    end
  end

  function automatic logic [15:0] cksum_expect();
`ifdef ROM_LOAD_CKSUM_EN
    return exp_sum;
`else
    return 16'h0000;
`endif
  endfunction

  // All tasks start and end just after a rising edge
  task automatic idle(input int n);
    repeat (n) begin
      #2 ioctl_wr = 1'b0;
      @(posedge clk_sys);
    end
  endtask

  task automatic rom_write(input logic [24:0] addr, input logic [7:0] data);
    bit acc;
    bit in_range;
    int tries;
    in_range = (32'(addr) < 32'h0001_0000);
    acc      = 1'b0;
    tries    = 0;
    while (!acc) begin
      #2;
      ioctl_wr    = 1'b1;
      ioctl_index = 8'd0;
      ioctl_addr  = addr;
      ioctl_dout  = data;
      @(negedge clk_sys);
      if (chk_lat && in_range) check("no_wait_when_ready", 32'(ioctl_wait), 32'd0);
      acc = !ioctl_wait || !in_range;
      if (acc && in_range) begin
        sb.push_back('{addr[16:0], data, cyc + 1, chk_lat});
        exp_sum = exp_sum + 16'(data);
        loaded  = 1'b1;
      end else if (acc) begin
        exp_ovf = 1'b1;
      end
      tries++;
      if (!acc && tries > 100) begin
        check("write_accept_timeout", 32'(tries), 32'd0);
        acc = 1'b1;
      end
      @(posedge clk_sys);
    end
  endtask

  task automatic raw_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    #2;
    ioctl_wr    = 1'b1;
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = data;
    @(posedge clk_sys);
    idle(1);
  endtask

  task automatic dip_expect(input string name, input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clk_sys);
    check({name, "_sw0"}, 32'(dip_sw0), 32'(d0));
    check({name, "_sw1"}, 32'(dip_sw1), 32'(d1));
    @(posedge clk_sys);
  endtask

  task automatic start_download();
    #2;
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b1;
    exp_sum        = '0;
    loaded         = 1'b0;
    exp_ovf        = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("entry_load_done", 32'(load_done), 32'd0);
    check("entry_overflow", 32'(overflow), 32'd0);
    check("entry_core_reset", 32'(core_reset), 32'd1);
    check("entry_cksum", 32'(cksum), 32'd0);
    @(posedge clk_sys);
  endtask

  task automatic end_download();
    int n;
    ready_mode = 0;
    #2;
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    if (loaded) begin
      n = 0;
      while (!load_done && n < 50) begin
        n++;
        @(negedge clk_sys);
      end
      check("load_done_set", 32'(load_done), 32'd1);
      n = 0;
      while (core_reset && n < 60) begin
        n++;
        @(negedge clk_sys);
      end
      check("hold_cycles", 32'(n), 32'd16);
    end else begin
      repeat (30) @(negedge clk_sys);
      check("load_done_without_bytes", 32'(load_done), 32'd0);
      check("core_reset_released", 32'(core_reset), 32'd0);
    end
    check("cksum", 32'(cksum), 32'(cksum_expect()));
    check("overflow_sticky", 32'(overflow), 32'(exp_ovf));
    check("all_bytes_written", 32'(sb.size()), 32'd0);
    @(posedge clk_sys);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit after %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] d;

    // Reset values
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_dn_wr", 32'(dn_wr), 32'd0);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_dip0", 32'(dip_sw0), 32'd0);
    check("rst_dip1", 32'(dip_sw1), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_cksum", 32'(cksum), 32'd0);
    check("rst_dn_addr", 32'(dn_addr), 32'd0);
    check("rst_dn_data", 32'(dn_data), 32'd0);
    @(posedge clk_sys);
    #2 reset_n = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("idle_core_reset", 32'(core_reset), 32'd1);
    @(posedge clk_sys);
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("idle_stays_in_reset", 32'(core_reset), 32'd1);
    @(posedge clk_sys);

    // DIP writes outside any download
    raw_write(8'd254, 25'd0, 8'hA5);
    dip_expect("dip_a5", 8'hA5, 8'h00);
    raw_write(8'd254, 25'd1, 8'h3C);
    dip_expect("dip_3c", 8'hA5, 8'h3C);
    raw_write(8'd254, 25'd2, 8'hFF);
    dip_expect("dip_addr2", 8'hA5, 8'h3C);
    raw_write(8'd254, 25'h1000001, 8'h11);
    dip_expect("dip_high_addr", 8'hA5, 8'h3C);
    raw_write(8'd7, 25'd0, 8'h22);
    dip_expect("other_index", 8'hA5, 8'h3C);

    // Four back-to-back bytes with the port always ready
    chk_lat = 1'b1;
    start_download();
    for (int i = 0; i < 4; i++) rom_write(25'(i), 8'(8'h10 + i));
    end_download();

    // Foreign index must neither write ROM nor flag overflow
    raw_write(8'd1, 25'h10000, 8'h55);
    @(negedge clk_sys);
    check("foreign_overflow", 32'(overflow), 32'd0);
    check("foreign_run", 32'(core_reset), 32'd0);
    @(posedge clk_sys);

    // Random bytes and gaps against a randomly ready port
    start_download();
    chk_lat    = 1'b0;
    ready_mode = 1;
    for (int i = 0; i < 24; i++) begin
      rom_write(25'(16'h0100 + i), 8'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    ready_mode = 0;
    idle(2);

    // Port stalls for 5 cycles while the stream keeps offering the next byte
    rom_write(25'h0200, 8'hC1);
    ready_mode = 2;
    #2;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h0201;
    ioctl_dout = 8'hC2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      check("stall_wait", 32'(ioctl_wait), 32'd1);
      check("stall_dn_wr", 32'(dn_wr), 32'd1);
      if (i == 4) ready_mode = 0;
      @(posedge clk_sys);
    end
    rom_write(25'h0201, 8'hC2);
    chk_lat = 1'b1;
    rom_write(25'h0202, 8'hC3);
    end_download();

    // One-cycle reset request while running
    @(negedge clk_sys);
    check("run_before_req", 32'(core_reset), 32'd0);
    @(posedge clk_sys);
    #2 reset_req = 1'b1;
    @(negedge clk_sys);
    check("req_core_reset", 32'(core_reset), 32'd1);
    @(posedge clk_sys);
    #2 reset_req = 1'b0;
    @(negedge clk_sys);
    n = 0;
    while (core_reset && n < 60) begin
      n++;
      @(negedge clk_sys);
    end
    check("req_hold_cycles", 32'(n), 32'd16);
    @(posedge clk_sys);

    // Download started in the middle of a hold
    #2 reset_req = 1'b1;
    @(posedge clk_sys);
    #2 reset_req = 1'b0;
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    check("mid_hold_load_done", 32'(load_done), 32'd1);
    check("mid_hold_core_reset", 32'(core_reset), 32'd1);
    @(posedge clk_sys);
    start_download();
    dip_expect("dip_after_load", 8'hA5, 8'h3C);
    for (int i = 0; i < 3; i++) rom_write(25'(16'h0300 + i), 8'($urandom));
    end_download();

    // Out-of-range ROM writes around the boundary
    start_download();
    rom_write(25'h10000, 8'h77);
    @(negedge clk_sys);
    check("overflow_at_size", 32'(overflow), 32'd1);
    @(posedge clk_sys);
    rom_write(25'h0FFFF, 8'h12);
    rom_write(25'h1000000, 8'h33);
    end_download();

    // A download made only of out-of-range bytes
    start_download();
    rom_write(25'h10005, 8'h44);
    end_download();

    // Long run of 0xFF bytes forces the checksum to wrap
    start_download();
    d = 8'hFF;
    for (int i = 0; i < 258; i++) rom_write(25'(i), d);
    end_download();

    dip_expect("dip_final", 8'hA5, 8'h3C);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
